// File: rtl/mmio_timer_irq.sv
// Memory-mapped 64-bit timer, compare, soft and external interrupt source.
// Answers single-cycle core data accesses in a 32-byte window at BASE.
module mmio_timer_irq #(
  parameter logic [31:0] BASE = 32'h0000_FF00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic [31:0] o_rdata,
  input  logic        i_ext_irq,
  output logic        o_interrupt
);

  localparam logic [2:0] A_MTIME_LO    = 3'd0;
  localparam logic [2:0] A_MTIME_HI    = 3'd1;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] A_CTRL        = 3'd4;
  localparam logic [2:0] A_MSIP        = 3'd5;
  localparam logic [2:0] A_PENDING     = 3'd6;
  localparam logic [2:0] A_PRESCALE    = 3'd7;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_pcnt;
  logic [15:0] r_prescale;
  logic [3:0]  r_ctrl;
  logic        r_msip;
  logic        r_tpend;
  logic        r_epend;
  logic        r_ext_q;
  logic        r_interrupt;

  logic        w_sel;
  logic        w_wr;
  logic [2:0]  w_idx;
  logic        w_wr_time_lo;
  logic        w_wr_time_hi;
  logic        w_tick;
  logic        w_edge;
  logic        w_clr_epend;
  logic [31:0] w_pending;
  logic [31:0] w_rdata;
  logic [1:0]  w_unused_addr;

  assign w_sel         = (i_addr[31:5] == BASE[31:5]);
  assign w_idx         = i_addr[4:2];
  assign w_wr          = w_sel & i_mem_write;
  assign w_wr_time_lo  = w_wr & (w_idx == A_MTIME_LO);
  assign w_wr_time_hi  = w_wr & (w_idx == A_MTIME_HI);
  assign w_tick        = r_ctrl[0] & (r_pcnt == r_prescale);
  assign w_edge        = i_ext_irq & ~r_ext_q;
  assign w_clr_epend   = w_wr & (w_idx == A_PENDING) & i_wdata[2];
  assign w_pending     = {29'd0, r_epend, r_msip, r_tpend};
  assign w_unused_addr = i_addr[1:0];
  assign o_rdata       = w_rdata;
  assign o_interrupt   = r_interrupt;

  // Zero-latency read mux; the bus is held at zero while reset is asserted.
  always_comb begin
    w_rdata = 32'd0;
    if (!i_rst_n) begin
      w_rdata = 32'd0;
    end else if (w_sel && i_mem_read) begin
      case (w_idx)
        A_MTIME_LO:    w_rdata = r_mtime[31:0];
        A_MTIME_HI:    w_rdata = r_mtime[63:32];
        A_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
        A_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
        A_CTRL:        w_rdata = {28'd0, r_ctrl};
        A_MSIP:        w_rdata = {31'd0, r_msip};
        A_PENDING:     w_rdata = w_pending;
        A_PRESCALE:    w_rdata = {16'd0, r_prescale};
        default:       w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  // Prescaler and mtime; a software write to either half beats the tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mtime <= 64'd0;
      r_pcnt  <= 16'd0;
    end else begin
      if (w_wr_time_lo || w_wr_time_hi) begin
        r_pcnt <= 16'd0;
      end else if (r_ctrl[0]) begin
        r_pcnt <= w_tick ? 16'd0 : (r_pcnt + 16'd1);
      end else begin
        r_pcnt <= r_pcnt;
      end

      if (w_wr_time_lo) begin
        r_mtime <= {r_mtime[63:32], i_wdata};
      end else if (w_wr_time_hi) begin
        r_mtime <= {i_wdata, r_mtime[31:0]};
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end else begin
        r_mtime <= r_mtime;
      end
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mtimecmp <= {64{1'b1}};
      r_ctrl     <= 4'd0;
      r_msip     <= 1'b0;
      r_prescale <= 16'd0;
    end else if (w_wr) begin
      case (w_idx)
        A_MTIMECMP_LO: r_mtimecmp <= {r_mtimecmp[63:32], i_wdata};
        A_MTIMECMP_HI: r_mtimecmp <= {i_wdata, r_mtimecmp[31:0]};
        A_CTRL:        r_ctrl     <= i_wdata[3:0];
        A_MSIP:        r_msip     <= i_wdata[0];
        A_PRESCALE:    r_prescale <= i_wdata[15:0];
        default:       r_ctrl     <= r_ctrl;
      endcase
    end else begin
      r_ctrl <= r_ctrl;
    end
  end

  // Pending sources and the registered request; a new edge beats a W1C.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tpend     <= 1'b0;
      r_epend     <= 1'b0;
      r_ext_q     <= 1'b0;
      r_interrupt <= 1'b0;
    end else begin
      r_tpend <= (r_mtime >= r_mtimecmp);
      r_ext_q <= i_ext_irq;
      if (w_edge) begin
        r_epend <= 1'b1;
      end else if (w_clr_epend) begin
        r_epend <= 1'b0;
      end else begin
        r_epend <= r_epend;
      end
      r_interrupt <= (r_tpend & r_ctrl[1]) | (r_msip & r_ctrl[2]) |
                     (r_epend & r_ctrl[3]);
    end
  end

endmodule

// File: tb/tb_mmio_timer_irq.sv
// Directed bench for mmio_timer_irq: reset, counting, timer/soft/ext IRQ, wrap, decode.
module tb_mmio_timer_irq;

  localparam logic [31:0] B = 32'h0000_FF00;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [31:0] o_rdata;
  logic        i_ext_irq = 1'b0;
  logic        o_interrupt;

  int checks = 0;
  int failures = 0;

  mmio_timer_irq #(.BASE(B)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .o_rdata(o_rdata),
    .i_ext_irq(i_ext_irq), .o_interrupt(o_interrupt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; commits at the next rising edge.
  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    i_addr = B + off;
    i_wdata = d;
    i_mem_write = 1'b1;
    @(negedge i_clk);
    i_mem_write = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    i_addr = B + off;
    i_mem_read = 1'b1;
    #1;
    chk(tag, o_rdata, exp);
    i_mem_read = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    // Reset held for two edges; bus gated to zero meanwhile.
    cycles(2);
    rdchk("rst_gated_rdata", 32'h08, 32'd0);
    i_rst_n = 1'b1;
    rdchk("rst_cmp_lo", 32'h08, 32'hFFFF_FFFF);
    rdchk("rst_cmp_hi", 32'h0C, 32'hFFFF_FFFF);
    rdchk("rst_mtime_lo", 32'h00, 32'd0);
    chk("rst_irq", {31'd0, o_interrupt}, 32'd0);

    // Counting with PRESCALE=3: one tick per 4 cycles.
    wr(32'h1C, 32'd3);
    wr(32'h10, 32'h1);
    cycles(40);
    rdchk("count_40", 32'h00, 32'd10);
    wr(32'h10, 32'h0);
    rdchk("count_stop", 32'h00, 32'd10);
    cycles(20);
    rdchk("count_hold", 32'h00, 32'd10);

    // Timer compare at 5 with one tick per cycle.
    wr(32'h1C, 32'd0);
    wr(32'h00, 32'd0);
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd5);
    wr(32'h10, 32'h3);
    cycles(5);
    rdchk("tmr_mtime5", 32'h00, 32'd5);
    chk("tmr_irq_n0", {31'd0, o_interrupt}, 32'd0);
    cycles(1);
    chk("tmr_irq_n1", {31'd0, o_interrupt}, 32'd0);
    rdchk("tmr_pending", 32'h18, 32'h1);
    cycles(1);
    chk("tmr_irq_n2", {31'd0, o_interrupt}, 32'd1);
    wr(32'h08, 32'd1000);
    chk("tmr_fall_0", {31'd0, o_interrupt}, 32'd1);
    cycles(1);
    chk("tmr_fall_1", {31'd0, o_interrupt}, 32'd1);
    cycles(1);
    chk("tmr_fall_2", {31'd0, o_interrupt}, 32'd0);

    // 64-bit wrap.
    wr(32'h10, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h00, 32'hFFFF_FFFE);
    rdchk("wrap_pre_hi", 32'h04, 32'hFFFF_FFFF);
    wr(32'h10, 32'h1);
    cycles(2);
    rdchk("wrap_lo", 32'h00, 32'd0);
    rdchk("wrap_hi", 32'h04, 32'd0);
    wr(32'h10, 32'h0);

    // External edge, set-beats-clear, then plain W1C.
    wr(32'h10, 32'h8);
    i_ext_irq = 1'b1;
    @(negedge i_clk);
    i_ext_irq = 1'b0;
    rdchk("ext_pending", 32'h18, 32'h4);
    chk("ext_irq_n0", {31'd0, o_interrupt}, 32'd0);
    cycles(1);
    chk("ext_irq_n1", {31'd0, o_interrupt}, 32'd1);
    i_ext_irq = 1'b1;
    wr(32'h18, 32'h4);
    i_ext_irq = 1'b0;
    rdchk("ext_set_wins", 32'h18, 32'h4);
    chk("ext_irq_held", {31'd0, o_interrupt}, 32'd1);
    wr(32'h18, 32'h4);
    rdchk("ext_cleared", 32'h18, 32'h0);
    chk("ext_fall_0", {31'd0, o_interrupt}, 32'd1);
    cycles(1);
    chk("ext_fall_1", {31'd0, o_interrupt}, 32'd0);

    // Software interrupt.
    wr(32'h10, 32'h4);
    wr(32'h14, 32'h1);
    chk("sw_irq_n0", {31'd0, o_interrupt}, 32'd0);
    cycles(1);
    chk("sw_irq_n1", {31'd0, o_interrupt}, 32'd1);
    rdchk("sw_pending", 32'h18, 32'h2);

    // Decode: accesses past the window change nothing and read zero.
    wr(32'h20, 32'h1234_5678);
    wr(32'h34, 32'h0);
    rdchk("dec_mtime", 32'h00, 32'd1);
    rdchk("dec_msip", 32'h14, 32'h1);
    rdchk("dec_read_out", 32'h20, 32'd0);
    cycles(1);
    chk("dec_irq", {31'd0, o_interrupt}, 32'd1);
    i_addr = B + 32'h14;
    #1;
    chk("no_read_zero", o_rdata, 32'd0);

    // Simultaneous read and write: pre-write value now, new value after.
    i_addr = B + 32'h1C;
    i_wdata = 32'd7;
    i_mem_read = 1'b1;
    i_mem_write = 1'b1;
    #1;
    chk("rw_prewrite", o_rdata, 32'd0);
    @(negedge i_clk);
    i_mem_write = 1'b0;
    i_mem_read = 1'b0;
    rdchk("rw_postwrite", 32'h1C, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
